// File: rtl/nn_comm_if.sv
// Byte-UART link between the host-link controller (master) and the UART (slave).
interface nn_comm_if;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_clear;
  logic [7:0] tx_byte;
  logic       tx_send;
  logic       tx_busy;

  modport master (input rx_byte, rx_valid, tx_busy, output rx_clear, tx_byte, tx_send);
  modport slave  (output rx_byte, rx_valid, tx_busy, input rx_clear, tx_byte, tx_send);
endinterface

// File: rtl/nn_comm_controller.sv
// Host-link controller: parses opcode-framed write/read commands from the UART for the perceptron array.
// Optional frame checksum enabled by defining NN_COMM_CHECKSUM_EN.
module nn_comm_controller #(
  parameter int N_CH        = 2,
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 120000
) (
  input  logic                     clk,
  input  logic                     rst,
  nn_comm_if.master                uart,
  input  logic [N_CH*DATA_W-1:0]   weights,
  input  logic [DATA_W-1:0]        result,
  output logic [N_CH*DATA_W-1:0]   payload,
  output logic                     weight_write,
  output logic                     input_write,
  output logic                     err
);
  localparam int B  = DATA_W / 8;
  localparam int NB = N_CH * B;
`ifdef NN_COMM_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif
  localparam int RD_LAST = NB + B + CK;
  localparam int CW = $clog2(RD_LAST + 1) + 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int PW = $clog2(N_CH * DATA_W);
  localparam int RW = $clog2(DATA_W);

  localparam logic [7:0] OP_RD = 8'd5, OP_WW = 8'd50, OP_WI = 8'd51;
  localparam logic [7:0] RSP_RD = 8'd100, RSP_OK = 8'd101, RSP_ERR = 8'd102;

  typedef enum logic [2:0] {
    S_IDLE, S_RX_CLR, S_RX_WAIT, S_COMMIT, S_ERR, S_TX_LOAD, S_TX_ACK, S_TX_WAIT
  } state_t;

  state_t                  state_q, state_d;
  logic [7:0]              op_q, op_d, resp_q, resp_d;
  logic [CW-1:0]           cnt_q, cnt_d, snd_q, snd_d, last_q, last_d;
  logic [TW-1:0]           to_q, to_d;
  logic [N_CH*DATA_W-1:0]  payload_q, payload_d;
  logic [7:0]              tx_sel;
`ifdef NN_COMM_CHECKSUM_EN
  logic [7:0]              rx_x_q, rx_x_d, tx_x_q, tx_x_d;
  logic                    ck_bad_q, ck_bad_d;
`endif

  // Bit offset of stream byte idx: channel-major, MSB byte of each word first.
  function automatic logic [PW-1:0] slot_off(input int idx);
    return PW'((idx / B) * DATA_W + (B - 1 - idx % B) * 8);
  endfunction

  assign payload = payload_q;

  // Response byte stream: code, weight bytes, result bytes, optional checksum.
  always_comb begin
    tx_sel = 8'h00;
    if (snd_q == '0)                  tx_sel = resp_q;
    else if (snd_q <= CW'(NB))        tx_sel = weights[slot_off(int'(snd_q) - 1) +: 8];
    else if (snd_q <= CW'(NB + B))    tx_sel = result[RW'((B - 1 - (int'(snd_q) - 1 - NB)) * 8) +: 8];
`ifdef NN_COMM_CHECKSUM_EN
    else                              tx_sel = tx_x_q;
`endif
  end

  always_comb begin
    state_d = state_q; op_d = op_q; resp_d = resp_q; cnt_d = cnt_q;
    snd_d = snd_q; last_d = last_q; to_d = to_q; payload_d = payload_q;
`ifdef NN_COMM_CHECKSUM_EN
    rx_x_d = rx_x_q; tx_x_d = tx_x_q; ck_bad_d = ck_bad_q;
`endif
    uart.rx_clear = 1'b0; uart.tx_send = 1'b0; uart.tx_byte = 8'h00;
    weight_write = 1'b0; input_write = 1'b0; err = 1'b0;
    case (state_q)
      S_IDLE: if (uart.rx_valid) begin
        op_d  = uart.rx_byte;
        to_d  = '0;
        cnt_d = (uart.rx_byte == OP_WW || uart.rx_byte == OP_WI) ? CW'(NB + CK) : '0;
`ifdef NN_COMM_CHECKSUM_EN
        rx_x_d   = uart.rx_byte;
        ck_bad_d = 1'b0;
`endif
        state_d = S_RX_CLR;
      end
      S_RX_CLR: begin
        uart.rx_clear = 1'b1;
        if (cnt_q != '0) state_d = S_RX_WAIT;
        else if (op_q == OP_RD) begin
          resp_d = RSP_RD; snd_d = '0; last_d = CW'(RD_LAST);
`ifdef NN_COMM_CHECKSUM_EN
          tx_x_d = 8'h00;
`endif
          state_d = S_TX_LOAD;
        end
        else if (op_q == OP_WW || op_q == OP_WI) begin
          state_d = S_COMMIT;
`ifdef NN_COMM_CHECKSUM_EN
          if (ck_bad_q) state_d = S_ERR;
`endif
        end
        else state_d = S_ERR;
      end
      S_RX_WAIT: if (uart.rx_valid) begin
        to_d    = '0;
        cnt_d   = cnt_q - CW'(1);
        state_d = S_RX_CLR;
`ifdef NN_COMM_CHECKSUM_EN
        rx_x_d = rx_x_q ^ uart.rx_byte;
        if (cnt_q == CW'(1)) ck_bad_d = (uart.rx_byte != rx_x_q);
        else
`endif
        payload_d[slot_off(NB + CK - int'(cnt_q)) +: 8] = uart.rx_byte;
      end else begin
        to_d = to_q + TW'(1);
        if (to_q == TW'(TIMEOUT_CYC - 1)) state_d = S_ERR;
      end
      S_COMMIT: begin
        weight_write = (op_q == OP_WW);
        input_write  = (op_q == OP_WI);
        resp_d = RSP_OK; snd_d = '0; last_d = '0;
        state_d = S_TX_LOAD;
      end
      S_ERR: begin
        err = 1'b1;
        resp_d = RSP_ERR; snd_d = '0; last_d = '0;
        state_d = S_TX_LOAD;
      end
      S_TX_LOAD: if (!uart.tx_busy) begin
        uart.tx_send = 1'b1;
        uart.tx_byte = tx_sel;
`ifdef NN_COMM_CHECKSUM_EN
        tx_x_d = tx_x_q ^ tx_sel;
`endif
        state_d = S_TX_ACK;
      end
      // One dead cycle so the UART can raise busy before we poll it.
      S_TX_ACK: state_d = S_TX_WAIT;
      S_TX_WAIT: if (!uart.tx_busy) begin
        if (snd_q == last_q) state_d = S_IDLE;
        else begin
          snd_d   = snd_q + CW'(1);
          state_d = S_TX_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE; op_q <= '0; resp_q <= '0; cnt_q <= '0;
      snd_q <= '0; last_q <= '0; to_q <= '0; payload_q <= '0;
`ifdef NN_COMM_CHECKSUM_EN
      rx_x_q <= '0; tx_x_q <= '0; ck_bad_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d; op_q <= op_d; resp_q <= resp_d; cnt_q <= cnt_d;
      snd_q <= snd_d; last_q <= last_d; to_q <= to_d; payload_q <= payload_d;
`ifdef NN_COMM_CHECKSUM_EN
      rx_x_q <= rx_x_d; tx_x_q <= tx_x_d; ck_bad_q <= ck_bad_d;
`endif
    end
  end
endmodule
